// File: rtl/segments_scan_pwm.sv
// Multiplexed segment scanner: per-digit dwell, enable mask, PWM brightness and frame snapshotting.
// Optional macro SEGSCAN_GHOST_BLANK_EN adds BLANK_CYCLES dead cycles at the start of every slot.
module segments_scan_pwm #(
    parameter int NUM_DIGITS   = 6,
    parameter int SEG_WIDTH    = 15,
    parameter int DWELL_LOG2   = 4,
    parameter int BRIGHT_W     = 2,
    parameter int BLANK_CYCLES = 2,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_DIGITS*SEG_WIDTH-1:0] digits,
    input  logic [NUM_DIGITS-1:0]           digit_en,
    input  logic [BRIGHT_W-1:0]             brightness,
    output logic [NUM_DIGITS-1:0]           column,
    output logic [SEG_WIDTH-1:0]            segments,
    output logic                            frame_start,
    output logic [IDX_W-1:0]                scan_idx
);

    if (DWELL_LOG2 < BRIGHT_W || BLANK_CYCLES >= (1 << DWELL_LOG2)) begin : g_bad_cfg
        $error("segments_scan_pwm: invalid DWELL_LOG2/BRIGHT_W/BLANK_CYCLES combination");
    end

    logic [IDX_W-1:0]      idx_p0;
    logic [DWELL_LOG2-1:0] cnt_p0;
    logic [IDX_W-1:0]      idx_p1;
    logic [DWELL_LOG2-1:0] cnt_p1;
    logic                  vld_p1;

    logic [SEG_WIDTH-1:0]  snap_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] snap_en;
    logic [BRIGHT_W-1:0]   snap_bright;

    logic                  frame_edge;
    logic [SEG_WIDTH-1:0]  sel_seg;
    logic                  sel_en;
    logic [NUM_DIGITS-1:0] col_nx;
    logic                  lit;

    // Duty window: the top BRIGHT_W bits of the slot counter select which quarter (etc.) of the slot we are in.
    function automatic logic duty_on(input logic [DWELL_LOG2-1:0] c, input logic [BRIGHT_W-1:0] b);
`ifdef SEGSCAN_GHOST_BLANK_EN
        return (c[DWELL_LOG2-1 -: BRIGHT_W] <= b) && (c >= DWELL_LOG2'(BLANK_CYCLES));
`else
        return (c[DWELL_LOG2-1 -: BRIGHT_W] <= b);
`endif
    endfunction

    assign frame_edge = (idx_p0 == '0) && (cnt_p0 == '0);

    // Stage 0: scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_p0 <= '0;
            cnt_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_p0 + DWELL_LOG2'(1);
            if (cnt_p0 == '1)
                idx_p0 <= (idx_p0 == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_p0 + IDX_W'(1);
        end
    end

    // Stage 1: delayed scan state and frame snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_p1      <= '0;
            cnt_p1      <= '0;
            vld_p1      <= 1'b0;
            snap_en     <= '0;
            snap_bright <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) snap_dig[i] <= '0;
        end else begin
            idx_p1 <= idx_p0;
            cnt_p1 <= cnt_p0;
            vld_p1 <= 1'b1;
            if (frame_edge) begin
                snap_en     <= digit_en;
                snap_bright <= brightness;
                for (int i = 0; i < NUM_DIGITS; i++)
                    snap_dig[i] <= digits[i*SEG_WIDTH +: SEG_WIDTH];
            end
        end
    end

    always_comb begin
        sel_seg = '0;
        sel_en  = 1'b0;
        col_nx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_p1 == IDX_W'(i)) begin
                sel_seg                  = snap_dig[i];
                sel_en                   = snap_en[i];
                col_nx[NUM_DIGITS-1-i]   = 1'b1;
            end
        end
        lit = vld_p1 && sel_en && duty_on(cnt_p1, snap_bright);
    end

    // Stage 2: registered outputs; vld_p1 keeps the first post-reset cycle quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            column      <= '0;
            segments    <= '0;
            frame_start <= 1'b0;
            scan_idx    <= '0;
        end else begin
            column      <= lit ? col_nx : '0;
            segments    <= lit ? sel_seg : '0;
            frame_start <= vld_p1 && (idx_p1 == '0) && (cnt_p1 == '0);
            scan_idx    <= idx_p1;
        end
    end

endmodule

// File: tb/tb_segments_scan_pwm.sv
// Scoreboard bench for segments_scan_pwm: frame-level reference model feeds a queue, a monitor compares each cycle.
module tb_segments_scan_pwm;
    localparam int N     = 6;
    localparam int SW    = 15;
    localparam int DL    = 4;
    localparam int BW    = 2;
    localparam int BLANK = 2;
    localparam int DW    = 1 << DL;
    localparam int FR    = N * DW;

    typedef struct packed {
        logic          fs;
        logic [2:0]    idx;
        logic [N-1:0]  col;
        logic [SW-1:0] seg;
    } out_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*SW-1:0] digits = '0;
    logic [N-1:0]    digit_en = '1;
    logic [BW-1:0]   brightness = 2'd3;
    logic [N-1:0]    column;
    logic [SW-1:0]   segments;
    logic            frame_start;
    logic [2:0]      scan_idx;

    segments_scan_pwm #(
        .NUM_DIGITS(N), .SEG_WIDTH(SW), .DWELL_LOG2(DL), .BRIGHT_W(BW), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .digit_en(digit_en), .brightness(brightness),
        .column(column), .segments(segments), .frame_start(frame_start), .scan_idx(scan_idx)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   e = 0;
    out_t q[$];
    logic [SW-1:0] m_dig [N];
    logic [N-1:0]  m_en;
    int            m_br;

    // Expected output for scan time s (cycles since the first post-reset edge), from frame-level rules.
    function automatic out_t model(int s);
        out_t o;
        int slot, c;
        bit on;
        slot = (s / DW) % N;
        c    = s % DW;
        on   = m_en[slot] && (c < (m_br + 1) * (DW >> BW));
`ifdef SEGSCAN_GHOST_BLANK_EN
        on   = on && (c >= BLANK);
`endif
        o.fs  = ((s % FR) == 0);
        o.idx = 3'(slot);
        o.col = on ? N'(1) << (N - 1 - slot) : '0;
        o.seg = on ? m_dig[slot] : '0;
        return o;
    endfunction

    task automatic chk(string name, out_t a, out_t x);
        tests++;
        if (a !== x) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s t=%0t got fs=%b idx=%0d col=%b seg=%h, want fs=%b idx=%0d col=%b seg=%h",
                         name, $time, a.fs, a.idx, a.col, a.seg, x.fs, x.idx, x.col, x.seg);
        end
    endtask

    // Predictor: mirrors the frame snapshot at each frame boundary and queues the expected response.
    always @(posedge clk) begin
        if (!rst_n) begin
            e = 0;
            q.delete();
        end else begin
            e++;
            if (((e - 1) % FR) == 0) begin
                for (int i = 0; i < N; i++) m_dig[i] = digits[i*SW +: SW];
                m_en = digit_en;
                m_br = int'(brightness);
            end
            q.push_back(model(e - 1));
        end
    end

    // Monitor: outputs lag the scan by two edges; before that, and in reset, everything is zero.
    always @(negedge clk) begin
        out_t act, exp;
        act = {frame_start, scan_idx, column, segments};
        if (!rst_n || e < 2) begin
            exp = '0;
            chk("reset_state", act, exp);
        end else if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty t=%0t got no expected entry, want one", $time);
        end else begin
            exp = q.pop_front();
            chk("scan_output", act, exp);
        end
    end

    task automatic wait_idx(int v);
        int n = 0;
        while (scan_idx !== 3'(v) && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL wait_idx got scan_idx=%0d, want %0d within 300 cycles", scan_idx, v);
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) digits[i*SW +: SW] = SW'($urandom);
        digit_en   = N'($urandom);
        brightness = BW'($urandom);
    endtask

    initial begin
        out_t act;
        for (int i = 0; i < N; i++) digits[i*SW +: SW] = SW'(1) << i;
        digit_en   = '1;
        brightness = 2'd3;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FR) @(negedge clk);

        brightness = 2'd1;
        repeat (2 * FR) @(negedge clk);

        brightness = 2'd3;
        digit_en   = 6'b000101;
        repeat (2 * FR) @(negedge clk);

        digit_en = '1;
        brightness = 2'd0;
        digits[3*SW +: SW] = 15'h0008;
        repeat (FR) @(negedge clk);
        wait_idx(1);
        digits[3*SW +: SW] = 15'h7FFF;
        repeat (2 * FR) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            randomize_inputs();
            repeat ($urandom_range(1, 2 * FR)) @(negedge clk);
        end

        randomize_inputs();
        digit_en = '1;
        wait_idx(4);
        #2 rst_n = 1'b0;
        #1 act = {frame_start, scan_idx, column, segments};
        chk("async_reset_immediate", act, out_t'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FR) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
